// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - 8x8 nibble-serial multiplier datapath driven by an external 4-step controller
// Optional 7-segment product display enabled by defining MULT_DATAPATH_SEG7_EN.
module mult_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  data_a,
    input  logic [7:0]  data_b,
    input  logic        sela,
    input  logic        selb,
    input  logic [1:0]  sel_shifter,
    input  logic        data_sel,
    input  logic        clk_en,
    input  logic        done_flag,
    output logic [2:0]  count,
    output logic [15:0] product,
    output logic        product_valid
`ifdef MULT_DATAPATH_SEG7_EN
    ,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
`endif
);

    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [7:0]  a_src;
    logic [7:0]  b_src;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  pp8;
    logic [15:0] pp_shifted;
    logic        done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 3'd0;
        end else if (!start) begin
            count <= 3'd0;
        end else if (count < 3'd4) begin
            count <= count + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= 8'd0;
            b_reg <= 8'd0;
        end else if (clk_en) begin
            a_reg <= data_a;
            b_reg <= data_b;
        end
    end

    // The capture cycle also computes the first partial product, so bypass the registers then
    assign a_src = clk_en ? data_a : a_reg;
    assign b_src = clk_en ? data_b : b_reg;
    assign nib_a = sela ? a_src[3:0] : a_src[7:4];
    assign nib_b = selb ? b_src[3:0] : b_src[7:4];
    assign pp8   = {4'd0, nib_a} * {4'd0, nib_b};

    always_comb begin
        pp_shifted = 16'd0;
        case (sel_shifter)
            2'b10:   pp_shifted = {8'd0, pp8};
            2'b01:   pp_shifted = {4'd0, pp8, 4'd0};
            2'b00:   pp_shifted = {pp8, 8'd0};
            default: pp_shifted = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product <= 16'd0;
        end else if (!done_flag) begin
            if (data_sel) begin
                product <= pp_shifted;
            end else begin
                product <= product + pp_shifted;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_d <= 1'b0;
        end else begin
            done_d <= done_flag;
        end
    end

    // Gated by rst so the pulse drops immediately on reset even if done_flag is still high
    assign product_valid = rst & done_flag & ~done_d;

`ifdef MULT_DATAPATH_SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hex0 <= 7'b1000000;
            hex1 <= 7'b1000000;
            hex2 <= 7'b1000000;
            hex3 <= 7'b1000000;
        end else if (product_valid) begin
            hex0 <= seg7(product[3:0]);
            hex1 <= seg7(product[7:4]);
            hex2 <= seg7(product[11:8]);
            hex3 <= seg7(product[15:12]);
        end
    end
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - self-checking bench for mult_datapath with a behavioural controller and product model
// Checks the hex display outputs as well when MULT_DATAPATH_SEG7_EN is defined.
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  data_a;
    logic [7:0]  data_b;
    logic        sela;
    logic        selb;
    logic [1:0]  sel_shifter;
    logic        data_sel;
    logic        clk_en;
    logic        done_flag;
    logic [2:0]  count;
    logic [15:0] product;
    logic        product_valid;
`ifdef MULT_DATAPATH_SEG7_EN
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_datapath dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_a        (data_a),
        .data_b        (data_b),
        .sela          (sela),
        .selb          (selb),
        .sel_shifter   (sel_shifter),
        .data_sel      (data_sel),
        .clk_en        (clk_en),
        .done_flag     (done_flag),
        .count         (count),
        .product       (product),
        .product_valid (product_valid)
`ifdef MULT_DATAPATH_SEG7_EN
        ,
        .hex0          (hex0),
        .hex1          (hex1),
        .hex2          (hex2),
        .hex3          (hex3)
`endif
    );

    // Controller: S0 low*low, S1/S2 cross terms <<4, S3 high*high <<8, then FINISH
    always_comb begin
        sela        = 1'b0;
        selb        = 1'b0;
        sel_shifter = 2'b11;
        data_sel    = 1'b1;
        clk_en      = 1'b0;
        done_flag   = 1'b0;
        if (start) begin
            clk_en    = (count == 3'd0);
            done_flag = (count == 3'd4);
            data_sel  = (count == 3'd0);
            case (count)
                3'd0: begin sela = 1'b1; selb = 1'b1; sel_shifter = 2'b10; end
                3'd1: begin sela = 1'b1; selb = 1'b0; sel_shifter = 2'b01; end
                3'd2: begin sela = 1'b0; selb = 1'b1; sel_shifter = 2'b01; end
                3'd3: begin sela = 1'b0; selb = 1'b0; sel_shifter = 2'b00; end
                default: sel_shifter = 2'b11;
            endcase
        end
    end

    int          m_count;
    logic [15:0] m_exp;
    logic        m_done_d;
    logic        m_done;

    assign m_done = start && (m_count == 4);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_count  <= 0;
            m_done_d <= 1'b0;
            m_exp    <= 16'd0;
        end else begin
            m_done_d <= m_done;
            if (!start) begin
                m_count <= 0;
            end else if (m_count < 4) begin
                m_count <= m_count + 1;
            end
            if (start && m_count == 0) begin
                m_exp <= 16'(data_a) * 16'(data_b);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("count", 32'(count), 32'(m_count));
            check("product_valid", 32'(product_valid), 32'(m_done && !m_done_d));
            if (m_done) begin
                check("product_hold", 32'(product), 32'(m_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                            input int hold, input int chg_at, input logic [7:0] chg_a);
        int lat;
        int pulses;
        lat    = 0;
        pulses = 0;
        data_a = a;
        data_b = b;
        start  = 1'b1;
        for (int i = 1; i <= 20 + hold; i++) begin
            step();
            if (i == chg_at) data_a = chg_a;
            if (product_valid) pulses++;
            if (lat == 0 && count == 3'd4) lat = i;
            if (lat != 0 && i >= lat + hold) break;
        end
        check("latency", 32'(lat), 32'd4);
        check("final_product", 32'(product), 32'(exp));
        check("valid_pulses", 32'(pulses), 32'd1);
        start = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        data_a = 8'd0;
        data_b = 8'd0;
        #1 rst = 1'b0;
        #1;
        check("reset_count", 32'(count), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_valid", 32'(product_valid), 32'd0);
`ifdef MULT_DATAPATH_SEG7_EN
        check("reset_hex0", 32'(hex0), 32'h40);
        check("reset_hex3", 32'(hex3), 32'h40);
`endif
        step();
        step();
        rst = 1'b1;
        step();

        run_mult(8'h12, 8'h34, 16'h03A8, 10, 0, 8'h00);
`ifdef MULT_DATAPATH_SEG7_EN
        check("hex0", 32'(hex0), 32'h00);
        check("hex1", 32'(hex1), 32'h08);
        check("hex2", 32'(hex2), 32'h30);
        check("hex3", 32'(hex3), 32'h40);
`endif
        run_mult(8'hFF, 8'hFF, 16'hFE01, 1, 0, 8'h00);
        run_mult(8'h00, 8'hFF, 16'h0000, 1, 0, 8'h00);
        run_mult(8'h12, 8'h34, 16'h03A8, 1, 2, 8'h99);

        data_a = 8'h12;
        data_b = 8'h34;
        start  = 1'b1;
        step();
        step();
        check("abort_count_before", 32'(count), 32'd2);
        start = 1'b0;
        step();
        check("abort_count_cleared", 32'(count), 32'd0);
        run_mult(8'h0F, 8'h10, 16'h00F0, 1, 0, 8'h00);

        data_a = 8'h12;
        data_b = 8'h34;
        start  = 1'b1;
        step();
        step();
        check("midreset_count_before", 32'(count), 32'd2);
        rst = 1'b0;
        #1;
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_product", 32'(product), 32'd0);
        check("midreset_valid", 32'(product_valid), 32'd0);
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        run_mult(8'hA5, 8'h3C, 16'h26AC, 2, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
